uart_bus_bridge: RTL

Serial debug/loader master for the SoC I/O bus. It receives command frames over a 9600-baud 8N1 UART line and turns them into single-cycle I/O bus writes or reads, driving the same `address`/data/`w_en`/`r_en` bus that the peripherals (UART, GPIO, timers) respond on. It returns an ACK byte or the read data over its own TX line. It sits beside the CPU as a second bus initiator; arbitration with the CPU is external and gated by `busy`.

---
 rtl/uart_bus_bridge_if.sv | 13 +
 rtl/uart_bus_bridge.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/uart_bus_bridge_if.sv
// uart_bus_bridge_if: I/O bus shared by a bus initiator and the peripherals
// address/dout/w_en/r_en: initiator to peripherals; din: peripheral read data
// busy: initiator owns the bus, used by external arbitration with the CPU
interface uart_bus_bridge_if;
  logic [7:0] address;
  logic [7:0] dout;
  logic [7:0] din;
  logic w_en;
  logic r_en;
  logic busy;
  modport master(output address, dout, w_en, r_en, busy, input din);
  modport slave(input address, dout, w_en, r_en, busy, output din);
endinterface

// File: rtl/uart_bus_bridge.sv
// uart_bus_bridge: UART command frames ('W' addr data / 'R' addr) turned into single I/O bus cycles
// clk, rst (async active-high); rx serial in (idle high); tx serial reply out (idle high)
// bus: master side of the I/O bus (address, dout, din, w_en, r_en, busy)
module uart_bus_bridge #(
  parameter logic [7:0] PRESCALE = 8'd103,
  parameter logic [15:0] TIMEOUT_TICKS = 16'd4096,
  parameter logic [7:0] CMD_WRITE = 8'h57,
  parameter logic [7:0] CMD_READ = 8'h52,
  parameter logic [7:0] ACK = 8'h06,
  parameter logic [7:0] NAK = 8'h15
) (
  input logic clk,
  input logic rst,
  input logic rx,
  output logic tx,
  uart_bus_bridge_if.master bus
);
  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_FERR} rx_state_t;
  typedef enum logic [3:0] {P_IDLE, P_ADDR_W, P_DATA, P_WR, P_ADDR_R, P_RD, P_RSTB, P_RWAIT, P_SEND} p_state_t;
  typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_t;
  rx_state_t r;
  p_state_t p;
  tx_state_t t;
  logic [7:0] tick_cnt, rsh, rx_byte, tx_byte, tsh;
  logic [3:0] rcnt, tcnt;
  logic [2:0] rbit, tbit;
  logic [15:0] to_cnt;
  logic tick, s1, s2, rx_valid, frame_err, take, tx_end;
  assign tick = tick_cnt == PRESCALE;
  // frame errors take priority over consumption so a bad frame never feeds the parser
  assign take = rx_valid && !frame_err && (p == P_IDLE || p == P_ADDR_W || p == P_DATA || p == P_ADDR_R);
  assign tx_end = tick && t == T_STOP && tcnt == 4'd15;
  always_ff @(posedge clk or posedge rst)
    if (rst) tick_cnt <= '0;
    else tick_cnt <= tick ? '0 : tick_cnt + 8'd1;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      r <= R_IDLE;
      rcnt <= '0;
      rbit <= '0;
      rsh <= '0;
      rx_byte <= '0;
      rx_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (take) rx_valid <= 1'b0;
      if (tick) begin
        s1 <= rx;
        s2 <= s1;
        case (r)
          R_IDLE: begin
            rcnt <= '0;
            rbit <= '0;
            if (!s1 && !s2) r <= R_START;
          end
          R_START: begin
            rcnt <= rcnt == 4'd7 ? 4'd0 : rcnt + 4'd1;
            if (rcnt == 4'd7) r <= s2 ? R_IDLE : R_DATA;
          end
          R_DATA: begin
            rcnt <= rcnt + 4'd1;
            if (rcnt == 4'd15) begin
              rsh <= {s2, rsh[7:1]};
              rbit <= rbit + 3'd1;
              if (rbit == 3'd7) r <= R_STOP;
            end
          end
          R_STOP: begin
            rcnt <= rcnt + 4'd1;
            if (rcnt == 4'd15) begin
              r <= s2 ? R_IDLE : R_FERR;
              if (s2) begin
                rx_byte <= rsh;
                rx_valid <= 1'b1;
              end else frame_err <= 1'b1;
            end
          end
          R_FERR: if (s1 && s2) r <= R_IDLE;
          default: r <= R_IDLE;
        endcase
      end
    end
  // w_en/r_en are raised one state after address/dout settle, so both are stable a clock before the strobe
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      p <= P_IDLE;
      bus.address <= '0;
      bus.dout <= '0;
      bus.w_en <= 1'b0;
      bus.r_en <= 1'b0;
      bus.busy <= 1'b0;
      tx_byte <= '0;
      to_cnt <= '0;
    end else begin
      bus.w_en <= 1'b0;
      bus.r_en <= 1'b0;
      to_cnt <= take ? '0 : to_cnt + {15'd0, tick};
      if (frame_err && p != P_SEND) begin
        p <= P_SEND;
        tx_byte <= NAK;
        bus.busy <= 1'b1;
      end else case (p)
        P_IDLE: if (rx_valid) begin
          bus.busy <= 1'b1;
          tx_byte <= NAK;
          p <= rx_byte == CMD_WRITE ? P_ADDR_W : rx_byte == CMD_READ ? P_ADDR_R : P_SEND;
        end
        P_ADDR_W, P_ADDR_R: if (rx_valid) begin
          bus.address <= rx_byte;
          p <= p == P_ADDR_W ? P_DATA : P_RD;
        end else if (to_cnt >= TIMEOUT_TICKS) begin
          p <= P_IDLE;
          bus.busy <= 1'b0;
        end
        P_DATA: if (rx_valid) begin
          bus.dout <= rx_byte;
          p <= P_WR;
        end else if (to_cnt >= TIMEOUT_TICKS) begin
          p <= P_IDLE;
          bus.busy <= 1'b0;
        end
        P_WR: begin
          bus.w_en <= 1'b1;
          tx_byte <= ACK;
          p <= P_SEND;
        end
        P_RD: begin
          bus.r_en <= 1'b1;
          p <= P_RSTB;
        end
        // r_en is high in this cycle; the peripheral registers din at its end
        P_RSTB: p <= P_RWAIT;
        P_RWAIT: begin
          tx_byte <= bus.din;
          p <= P_SEND;
        end
        P_SEND: if (tx_end) begin
          p <= P_IDLE;
          bus.busy <= 1'b0;
        end
        default: p <= P_IDLE;
      endcase
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      t <= T_IDLE;
      tx <= 1'b1;
      tcnt <= '0;
      tbit <= '0;
      tsh <= '0;
    end else if (tick) case (t)
      T_IDLE: if (p == P_SEND) begin
        t <= T_START;
        tx <= 1'b0;
        tsh <= tx_byte;
        tcnt <= '0;
      end
      T_START: begin
        tcnt <= tcnt + 4'd1;
        if (tcnt == 4'd15) begin
          t <= T_DATA;
          tx <= tsh[0];
          tbit <= '0;
        end
      end
      T_DATA: begin
        tcnt <= tcnt + 4'd1;
        if (tcnt == 4'd15) begin
          tsh <= tsh >> 1;
          tbit <= tbit + 3'd1;
          t <= tbit == 3'd7 ? T_STOP : T_DATA;
          tx <= tbit == 3'd7 ? 1'b1 : tsh[1];
        end
      end
      T_STOP: begin
        tcnt <= tcnt + 4'd1;
        if (tcnt == 4'd15) t <= T_IDLE;
      end
    endcase
endmodule
